// File: rtl/sar_compare_search_if.sv
// Comparator-side bus of the SAR search controller: start request, comparator flags,
// and the trial/result outputs.
interface sar_compare_search_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic             cmp_equal;
  logic             cmp_lesser;
  logic             cmp_greater;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             matched;
  logic             error;

  modport master (
    output start, cmp_equal, cmp_lesser, cmp_greater,
    input  trial, busy, done, result, matched, error
  );

  modport slave (
    input  start, cmp_equal, cmp_lesser, cmp_greater,
    output trial, busy, done, result, matched, error
  );
endinterface

// File: rtl/sar_compare_search.sv
// Successive-approximation search: drives a trial operand into an external comparator and
// recovers the hidden target MSB first, one bit decision per flag sample.
module sar_compare_search #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SETTLE_CYCLES = 0
) (
  input logic                 clk,
  input logic                 rst,
  sar_compare_search_if.slave bus
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] SettleInit = CntW'(SETTLE_CYCLES);
  localparam logic [IdxW-1:0] IdxInit    = IdxW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] TrialInit = WIDTH'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StTrial, StDone} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_trial;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_matched;
  logic             r_error;
  logic [IdxW-1:0]  r_idx;
  logic [CntW-1:0]  r_cnt;

  logic [2:0]       w_flags;
  logic [WIDTH-1:0] w_bit_mask;
  logic [WIDTH-1:0] w_trial_upd;

  assign w_flags     = {bus.cmp_equal, bus.cmp_lesser, bus.cmp_greater};
  assign w_bit_mask  = WIDTH'(1) << r_idx;
  // Only a greater decision clears the bit under test; lesser keeps it.
  assign w_trial_upd = bus.cmp_greater ? (r_trial & ~w_bit_mask) : r_trial;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_trial   <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_matched <= 1'b0;
      r_error   <= 1'b0;
      r_idx     <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (bus.start) begin
            r_trial   <= TrialInit;
            r_idx     <= IdxInit;
            r_cnt     <= SettleInit;
            r_matched <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= StTrial;
          end
        end
        StTrial: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            case (w_flags)
              3'b100: begin
                r_result  <= r_trial;
                r_matched <= 1'b1;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_state   <= StDone;
              end
              3'b010, 3'b001: begin
                if (r_idx == '0) begin
                  r_trial  <= w_trial_upd;
                  r_result <= w_trial_upd;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= StDone;
                end else begin
                  // Tentatively set the next lower bit for the following compare.
                  r_trial <= w_trial_upd | (w_bit_mask >> 1);
                  r_idx   <= r_idx - 1'b1;
                  r_cnt   <= SettleInit;
                end
              end
              default: begin
                r_error  <= 1'b1;
                r_result <= '0;
                r_busy   <= 1'b0;
                r_done   <= 1'b1;
                r_state  <= StDone;
              end
            endcase
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign bus.trial   = r_trial;
  assign bus.result  = r_result;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.matched = r_matched;
  assign bus.error   = r_error;

endmodule

// File: tb/tb_sar_compare_search.sv
// Bench for sar_compare_search: two instances (settle 0 and settle 2) sharing one target,
// with a behavioural comparator and a scoreboard of expected search outcomes.
module tb_sar_compare_search;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sar_compare_search_if #(.WIDTH(W)) if_a ();
  sar_compare_search_if #(.WIDTH(W)) if_b ();

  sar_compare_search #(.WIDTH(W), .SETTLE_CYCLES(0)) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));
  sar_compare_search #(.WIDTH(W), .SETTLE_CYCLES(2)) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

  logic         sel;
  logic         start;
  logic [W-1:0] target;
  logic         ovr_en;
  logic [2:0]   ovr_flags;

  // Comparator model; ovr_en forces arbitrary (possibly invalid) flag patterns.
  assign if_a.start = start & ~sel;
  assign if_b.start = start & sel;
  assign {if_a.cmp_equal, if_a.cmp_lesser, if_a.cmp_greater} = ovr_en ? ovr_flags :
      {if_a.trial == target, if_a.trial < target, if_a.trial > target};
  assign {if_b.cmp_equal, if_b.cmp_lesser, if_b.cmp_greater} = ovr_en ? ovr_flags :
      {if_b.trial == target, if_b.trial < target, if_b.trial > target};

  logic [W-1:0] m_trial, m_result;
  logic         m_busy, m_done, m_matched, m_error;
  assign m_trial   = sel ? if_b.trial   : if_a.trial;
  assign m_result  = sel ? if_b.result  : if_a.result;
  assign m_busy    = sel ? if_b.busy    : if_a.busy;
  assign m_done    = sel ? if_b.done    : if_a.done;
  assign m_matched = sel ? if_b.matched : if_a.matched;
  assign m_error   = sel ? if_b.error   : if_a.error;

  typedef struct {
    logic [W-1:0] result;
    logic         matched;
    logic         error;
    int unsigned  lat;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_trial"}, m_trial, 0);
    check_eq({tag, "_result"}, m_result, 0);
    check_eq({tag, "_busy"}, m_busy, 0);
    check_eq({tag, "_done"}, m_done, 0);
    check_eq({tag, "_matched"}, m_matched, 0);
    check_eq({tag, "_error"}, m_error, 0);
  endtask

  // One search: model the expected trial sequence, push the outcome, drive start, then
  // follow the DUT cycle by cycle until done. poke_edge >= 0 pulses start at that cycle.
  task automatic run(input logic s, input logic [W-1:0] tgt, input logic oe,
                     input logic [2:0] of, input int poke_edge, input string tag);
    int unsigned  settle;
    logic [W-1:0] seq[$];
    logic [W-1:0] t;
    int unsigned  n;
    int unsigned  edges;
    int unsigned  k;
    bit           got;
    exp_t         e;
    exp_t         o;

    settle = s ? 2 : 0;
    t = W'(1) << (W - 1);
    seq.push_back(t);
    n = 0;
    if (oe) begin
      n = 1;
      e.result = '0; e.matched = 1'b0; e.error = 1'b1;
    end else begin
      for (int i = int'(W) - 1; i >= 0; i--) begin
        n++;
        if (t == tgt) break;
        if (t > tgt) t[i] = 1'b0;
        if (i > 0) t[i-1] = 1'b1;
        seq.push_back(t);
      end
      e.result = tgt; e.matched = (tgt != 0); e.error = 1'b0;
    end
    e.lat = n * (settle + 1);

    sel = s; target = tgt; ovr_en = oe; ovr_flags = of;
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;

    edges = 0;
    got = 1'b0;
    while (!got && edges < 200) begin
      if (edges == 0) begin
        check_eq({tag, "_clr_err"}, m_error, 0);
        check_eq({tag, "_clr_match"}, m_matched, 0);
      end
      if (m_done) begin
        got = 1'b1;
        if (sb_q.size() == 0) begin
          check_eq({tag, "_sb_empty"}, 1, 0);
        end else begin
          o = sb_q.pop_front();
          check_eq({tag, "_lat"}, edges, o.lat);
          check_eq({tag, "_result"}, m_result, o.result);
          check_eq({tag, "_matched"}, m_matched, o.matched);
          check_eq({tag, "_error"}, m_error, o.error);
          check_eq({tag, "_busy_done"}, m_busy, 0);
          check_eq({tag, "_trial_end"}, m_trial, seq[seq.size()-1]);
        end
      end else begin
        k = edges / (settle + 1);
        if (k >= seq.size()) k = seq.size() - 1;
        check_eq({tag, "_busy"}, m_busy, 1);
        check_eq({tag, "_trial"}, m_trial, seq[k]);
      end
      start = (poke_edge >= 0 && edges == poke_edge);
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    if (!got) check_eq({tag, "_timeout"}, 0, 1);
    check_eq({tag, "_done_pulse"}, m_done, 0);
    check_eq({tag, "_idle_busy"}, m_busy, 0);
    ovr_en = 1'b0;
  endtask

  initial begin
    int unsigned seen;
    rst = 1'b1; start = 1'b0; sel = 1'b0; target = '0; ovr_en = 1'b0; ovr_flags = '0;
    repeat (2) @(negedge clk);
    check_idle_zero("rst_a");
    sel = 1'b1;
    check_idle_zero("rst_b");
    rst = 1'b0;
    @(negedge clk);

    run(1'b0, 4'd12, 1'b0, 3'b000, -1, "t12");
    run(1'b0, 4'd0,  1'b0, 3'b000, -1, "t0");
    run(1'b0, 4'd5,  1'b0, 3'b000, -1, "t5");
    run(1'b0, 4'd15, 1'b0, 3'b000, -1, "t15");
    for (int v = 0; v < 16; v++) run(1'b0, W'(v), 1'b0, 3'b000, -1, "sweep");

    run(1'b1, 4'd9, 1'b0, 3'b000, -1, "s2_t9");
    repeat (4) run(1'b1, W'($urandom_range(0, 15)), 1'b0, 3'b000, -1, "s2_rand");

    run(1'b0, 4'd7, 1'b1, 3'b000, -1, "err000");
    run(1'b0, 4'd7, 1'b1, 3'b110, -1, "err110");
    run(1'b0, 4'd7, 1'b0, 3'b000, -1, "after_err");
    run(1'b1, 4'd3, 1'b1, 3'b111, -1, "s2_err111");

    run(1'b0, 4'd6, 1'b0, 3'b000, 1, "poke_trial");
    run(1'b1, 4'd10, 1'b0, 3'b000, 4, "s2_poke_trial");
    run(1'b0, 4'd3, 1'b0, 3'b000, 4, "poke_done");

    // Reset mid-search: outputs clear and the aborted search never signals done.
    sel = 1'b1; target = 4'd9;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid_busy", m_busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_rst");
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (m_done) seen++;
    end
    check_eq("mid_no_done", seen, 0);
    check_eq("mid_idle_busy", m_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sar_compare_search.md
Name: sar_compare_search

Overview:
- Successive-approximation controller that drives the operand side of an external magnitude comparator (equal/lesser/greater flags) and consumes its result flags.
- Binary-searches an unknown WIDTH-bit target held on the comparator's other operand, MSB first, one bit decision per compare.
- Returns the recovered target value.
- Used for threshold/value recovery wherever only a comparator against the target is available.

Parameters:
- WIDTH, 4, width of trial/result; search range 0 .. 2^WIDTH-1.
- SETTLE_CYCLES, 0, extra idle cycles after each trial update before the flags are sampled (comparator/path settling); 0 = sample on the next edge.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a search; accepted only in IDLE.
- cmp_equal  input  1  comparator flag: trial == target.
- cmp_lesser  input  1  comparator flag: trial < target.
- cmp_greater  input  1  comparator flag: trial > target.
- trial  output  WIDTH  registered operand driven to the comparator.
- busy  output  1  high while the search is in progress.
- done  output  1  one-cycle pulse when the search ends.
- result  output  WIDTH  recovered value; valid from done, held until the next accepted start.
- matched  output  1  search ended on cmp_equal; held with result.
- error  output  1  flags were invalid at a sample; held with result.

Behaviour:
- Reset (synchronous, rst=1 at edge): state IDLE; trial, result = 0; busy, done, matched, error = 0; wait counter and bit index cleared.
- rst has priority over all other inputs. Reset mid-search aborts the search: no done pulse, outputs return to reset values.
- States: IDLE, TRIAL, DONE.
- IDLE: on start=1 at an edge:
  - trial <= 1<<(WIDTH-1); bit index <= WIDTH-1; wait counter <= SETTLE_CYCLES.
  - matched, error <= 0; busy <= 1; go to TRIAL.
  - trial holds its last value while idle.
- TRIAL, wait counter != 0: decrement the counter; flags are ignored.
- TRIAL, wait counter == 0 (sample edge): flags are valid only if exactly one is high. Action by flag:
  - None or more than one high: error <= 1; result <= 0; go to DONE.
  - cmp_equal: result <= trial; matched <= 1; go to DONE (early exit).
  - cmp_greater: clear trial[index].
  - cmp_lesser: keep trial[index].
  - After a greater/lesser decision at index 0: result <= updated trial; go to DONE.
  - Otherwise: set trial[index-1]; index decrements; counter <= SETTLE_CYCLES.
- DONE: done = 1 and busy = 0 for exactly one cycle; then IDLE. start is ignored in DONE.
- start is ignored while busy; there is no queueing.
- Latency: with no early exit, the k-th flag sample occurs k*(SETTLE_CYCLES+1) edges after the start-accept edge. done is high in the cycle following the final sample. Worst case WIDTH*(SETTLE_CYCLES+1) samples-worth of cycles; an early equal exit shortens this proportionally.
- Convergence: with valid flags, result always equals the target. Target 0 is the only value that never produces cmp_equal (matched=0, result=0).
- trial only changes on sample edges or start acceptance. It is stable throughout every settle window.

Test Plan:
- WIDTH=4, SETTLE=0, target 12 -> trial 8 (lesser), 12 (equal); done 2 cycles after start accept; result=12, matched=1, error=0.
- Target 0 -> trials 8,4,2,1, all greater; done after 4 samples; result=0, matched=0.
- Targets 5 and 15 -> trial sequences 8,4,6,5 and 8,12,14,15; result=5/15, matched=1. Sweep all 16 targets -> result==target every time.
- SETTLE=2, target 9 -> trial changes only every 3 cycles (8,12,10,9); done 12 cycles after start accept; result=9.
- Flags forced 000, then 110, at the first sample -> error=1, result=0, one-cycle done; the next start clears error.
- start pulsed during TRIAL and during DONE -> ignored. rst asserted mid-search -> no done; trial/result/flags return to 0 on the next edge.
